// File: rtl/mac_pkg.sv
// Shared constants and FSM state encoding for the MAC feeder slice.
package mac_pkg;

    localparam int DEF_N_LEN    = 16;
    localparam int DEF_Q_LEN    = 8;
    localparam int DEF_DRAIN    = 3;
    localparam int DEF_MAX_WAIT = 8;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/mac_wait_timer.sv
// Loadable down-counter guarding the wait for the MAC result.
// The expiry flag is registered and rises on the step that reaches zero.
module mac_wait_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          expired
);

    logic [TW-1:0] cnt_r;
    logic          expired_r;

    // Reload restarts the window; each enabled cycle steps one count toward zero
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r     <= '0;
            expired_r <= 1'b0;
        end else if (load) begin
            cnt_r     <= load_val;
            expired_r <= (load_val == '0);
        end else if (en && (cnt_r != '0)) begin
            cnt_r     <= cnt_r - TW'(1'b1);
            expired_r <= (cnt_r == TW'(1'b1));
        end else begin
            cnt_r     <= cnt_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/mac_feeder.sv
// Streams signed operand pairs into an external MAC, drains its pipeline,
// then captures the accumulated result (or a timeout) for a downstream consumer.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int N_LEN    = DEF_N_LEN,
    parameter int Q_LEN    = DEF_Q_LEN,
    parameter int DRAIN    = DEF_DRAIN,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_LEN-1:0]        s_a,
    input  logic [N_LEN-1:0]        s_b,
    input  logic                    s_last,
    output logic                    mac_ce,
    output logic                    mac_sload,
    output logic [N_LEN-1:0]        mac_a,
    output logic [N_LEN-1:0]        mac_b,
    input  logic                    mac_rvalid,
    input  logic signed [N_LEN-1:0] mac_res,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_LEN-1:0]        m_data,
    output logic [CNT_W-1:0]        m_len,
    output logic                    m_err,
    output logic                    busy
);

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam int TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN - 1);
    localparam logic [TW-1:0]    WAIT_LOAD  = TW'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // Q_LEN only describes the MAC's number format; reject nonsensical sets early
    if ((Q_LEN < 0) || (Q_LEN >= N_LEN) || (DRAIN < 1) || (MAX_WAIT < 1)) begin : g_param_check
        $error("mac_feeder: unsupported parameter set");
    end

    feeder_state_e    state_r, state_nxt_s;
    logic             xfer_s;
    logic             timer_load_s, timer_en_s, timer_expired_s;

    logic             s_ready_r, s_ready_d_s;
    logic             busy_r, busy_d_s;
    logic             mac_ce_r;
    logic             mac_sload_r, mac_sload_d_s;
    logic [N_LEN-1:0] mac_a_r, mac_a_d_s, mac_b_r, mac_b_d_s;
    logic [DW-1:0]    drain_cnt_r, drain_cnt_d_s;
    logic [CNT_W-1:0] pair_cnt_r, pair_cnt_d_s;
    logic             m_valid_r, m_valid_d_s;
    logic [N_LEN-1:0] m_data_r, m_data_d_s;
    logic [CNT_W-1:0] m_len_r, m_len_d_s;
    logic             m_err_r, m_err_d_s;

    assign xfer_s       = s_valid & s_ready_r;
    assign timer_load_s = (state_r == ST_DRAIN) && (state_nxt_s == ST_WAIT);
    assign timer_en_s   = (state_r == ST_WAIT);

    mac_wait_timer #(.TW(TW)) u_wait_timer (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (timer_load_s),
        .load_val (WAIT_LOAD),
        .en       (timer_en_s),
        .expired  (timer_expired_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ACC: begin
                if (xfer_s) begin
                    state_nxt_s = s_last ? ST_DRAIN : ST_ACC;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_WAIT: begin
                if (mac_rvalid || timer_expired_s) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of every registered output, derived from the upcoming state
    always_comb begin
        s_ready_d_s   = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACC);
        busy_d_s      = (state_nxt_s != ST_IDLE);
        // The accumulator is protected whenever no vector is streaming or draining
        mac_sload_d_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_WAIT) ||
                        (state_nxt_s == ST_OUT);
        mac_a_d_s     = '0;
        mac_b_d_s     = '0;
        drain_cnt_d_s = '0;
        pair_cnt_d_s  = pair_cnt_r;
        m_valid_d_s   = m_valid_r;
        m_data_d_s    = m_data_r;
        m_len_d_s     = m_len_r;
        m_err_d_s     = m_err_r;

        if (xfer_s) begin
            mac_a_d_s = s_a;
            mac_b_d_s = s_b;
        end else begin
            mac_a_d_s = '0;
            mac_b_d_s = '0;
        end

        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    pair_cnt_d_s = CNT_W'(1'b1);
                end else begin
                    pair_cnt_d_s = pair_cnt_r;
                end
            end
            ST_ACC: begin
                if (xfer_s && (pair_cnt_r != CNT_MAX)) begin
                    pair_cnt_d_s = pair_cnt_r + CNT_W'(1'b1);
                end else begin
                    pair_cnt_d_s = pair_cnt_r;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r != DRAIN_LAST) begin
                    drain_cnt_d_s = drain_cnt_r + DW'(1'b1);
                end else begin
                    drain_cnt_d_s = '0;
                end
            end
            ST_WAIT: begin
                if (mac_rvalid) begin
                    m_valid_d_s = 1'b1;
                    m_data_d_s  = mac_res;
                    m_len_d_s   = pair_cnt_r;
                    m_err_d_s   = 1'b0;
                end else if (timer_expired_s) begin
                    m_valid_d_s = 1'b1;
                    m_data_d_s  = '0;
                    m_len_d_s   = pair_cnt_r;
                    m_err_d_s   = 1'b1;
                end else begin
                    m_valid_d_s = 1'b0;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d_s = 1'b0;
                end else begin
                    m_valid_d_s = 1'b1;
                end
            end
            default: begin
                pair_cnt_d_s = '0;
                m_valid_d_s  = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_ready_r   <= 1'b1;
            busy_r      <= 1'b0;
            mac_ce_r    <= 1'b1;
            mac_sload_r <= 1'b1;
            mac_a_r     <= '0;
            mac_b_r     <= '0;
            drain_cnt_r <= '0;
            pair_cnt_r  <= '0;
            m_valid_r   <= 1'b0;
            m_data_r    <= '0;
            m_len_r     <= '0;
            m_err_r     <= 1'b0;
        end else begin
            s_ready_r   <= s_ready_d_s;
            busy_r      <= busy_d_s;
            mac_ce_r    <= 1'b1;
            mac_sload_r <= mac_sload_d_s;
            mac_a_r     <= mac_a_d_s;
            mac_b_r     <= mac_b_d_s;
            drain_cnt_r <= drain_cnt_d_s;
            pair_cnt_r  <= pair_cnt_d_s;
            m_valid_r   <= m_valid_d_s;
            m_data_r    <= m_data_d_s;
            m_len_r     <= m_len_d_s;
            m_err_r     <= m_err_d_s;
        end
    end

    assign s_ready   = s_ready_r;
    assign busy      = busy_r;
    assign mac_ce    = mac_ce_r;
    assign mac_sload = mac_sload_r;
    assign mac_a     = mac_a_r;
    assign mac_b     = mac_b_r;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign m_len     = m_len_r;
    assign m_err     = m_err_r;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder paired with a behavioural Q8.8 MAC; a vector-level
// model predicts each result and a monitor checks every output cycle.
module tb_mac_feeder;

    localparam int N  = 16;
    localparam int Q  = 8;
    localparam int DR = 3;
    localparam int MW = 8;
    localparam int CW = 8;

    typedef struct packed {
        logic [N-1:0]  data;
        logic [CW-1:0] len;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          arst_n = 1'b1;
    logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [N-1:0]  s_a = '0, s_b = '0;
    logic          s_ready, mac_ce, mac_sload, mac_rvalid, m_valid, m_err, busy;
    logic [N-1:0]  mac_a, mac_b, m_data;
    logic [CW-1:0] m_len;

    logic signed [N-1:0] mac_acc_r, mac_res_r;
    logic                mac_rv_r, mac_prev_sload_r;
    logic signed [2*N-1:0] mac_p;
    bit                  rvalid_en = 1'b1;

    int   n_vec = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    logic [N-1:0] pa[$], pb[$];

    always #5 clk = ~clk;

    mac_feeder #(.N_LEN(N), .Q_LEN(Q), .DRAIN(DR), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last), .mac_ce(mac_ce), .mac_sload(mac_sload),
        .mac_a(mac_a), .mac_b(mac_b), .mac_rvalid(mac_rvalid), .mac_res(mac_res_r),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len),
        .m_err(m_err), .busy(busy)
    );

    // Team MAC: sload clears, otherwise accumulates; the rising sload dumps the sum
    assign mac_p = $signed(mac_a) * $signed(mac_b);
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mac_acc_r <= '0; mac_res_r <= '0; mac_rv_r <= 1'b0; mac_prev_sload_r <= 1'b1;
        end else if (mac_ce) begin
            mac_prev_sload_r <= mac_sload;
            mac_rv_r         <= mac_sload && !mac_prev_sload_r;
            if (mac_sload && !mac_prev_sload_r) mac_res_r <= mac_acc_r;
            mac_acc_r <= mac_sload ? '0 : mac_acc_r + N'(mac_p >>> Q);
        end
    end
    assign mac_rvalid = mac_rv_r & rvalid_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected result of the vector held in pa/pb, from fixed-point arithmetic
    function automatic res_t model(input bit stub);
        res_t r;
        logic signed [N-1:0]   acc;
        logic signed [2*N-1:0] p;
        acc = '0;
        foreach (pa[i]) begin
            p   = $signed(pa[i]) * $signed(pb[i]);
            acc = acc + N'(p >>> Q);
        end
        r.len  = (pa.size() > 255) ? CW'(255) : CW'(pa.size());
        r.err  = stub;
        r.data = stub ? '0 : acc;
        return r;
    endfunction

    // Monitor: result against model on the rising m_valid, stability while held
    logic         mv_prev = 1'b0;
    logic [N-1:0] held_d;
    logic [CW-1:0] held_l;
    logic         held_e;
    res_t         e_mon;
    always @(negedge clk) begin
        if (!arst_n) begin
            mv_prev = 1'b0;
        end else begin
            chk("mac_ce_high", mac_ce, 1);
            if (m_valid && !mv_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", m_valid, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("model_data", m_data, e_mon.data);
                    chk("model_len", m_len, e_mon.len);
                    chk("model_err", m_err, e_mon.err);
                end
                held_d = m_data; held_l = m_len; held_e = m_err;
            end else if (m_valid) begin
                chk("hold_data", m_data, held_d);
                chk("hold_len", m_len, held_l);
                chk("hold_err", m_err, held_e);
                chk("out_s_ready", s_ready, 0);
            end
            mv_prev = m_valid;
        end
    end

    task automatic push_pair(input logic [N-1:0] a, input logic [N-1:0] b);
        pa.push_back(a); pb.push_back(b);
    endtask

    task automatic run_vec(input string tag, input int gap, input bit stub, input int hold,
                           input logic [N-1:0] lit_data, input logic [CW-1:0] lit_len,
                           input logic lit_err);
        int k;
        int w;
        rvalid_en = !stub;
        exp_q.push_back(model(stub));
        for (int i = 0; i < pa.size(); i++) begin
            s_valid = 1'b1; s_a = pa[i]; s_b = pb[i]; s_last = (i == pa.size() - 1);
            w = 0;
            while (s_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            if (w >= 20) chk({tag, "_s_ready_wait"}, s_ready, 1);
            @(posedge clk);
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0;
            if (i < pa.size() - 1) repeat (gap) @(negedge clk);
        end
        chk({tag, "_drain_busy"}, busy, 1);
        chk({tag, "_drain_s_ready"}, s_ready, 0);
        chk({tag, "_drain_sload"}, mac_sload, 0);
        k = 0;
        while (m_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk({tag, "_latency"}, k, stub ? (DR + MW) : (DR + 2));
        chk({tag, "_lit_data"}, m_data, lit_data);
        chk({tag, "_lit_len"}, m_len, lit_len);
        chk({tag, "_lit_err"}, m_err, lit_err);
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1; s_a = 16'h7FFF; s_b = 16'h7FFF; s_last = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_valid"}, m_valid, 1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_done_valid"}, m_valid, 0);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_s_ready"}, s_ready, 1);
        rvalid_en = 1'b1;
        pa.delete(); pb.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_sload"}, mac_sload, 1);
        chk({tag, "_ce"}, mac_ce, 1);
        chk({tag, "_mac_a"}, mac_a, 0);
        chk({tag, "_mac_b"}, mac_b, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_len"}, m_len, 0);
        chk({tag, "_m_err"}, m_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1 arst_n = 1'b0;
        #2 chk_reset_state("rst");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        push_pair(16'h0100, 16'h0200); push_pair(16'h0080, 16'h0400);
        run_vec("two_pair", 0, 1'b0, 0, 16'h0400, 8'd2, 1'b0);

        push_pair(16'h0100, 16'hFF00);
        run_vec("single", 0, 1'b0, 0, 16'hFF00, 8'd1, 1'b0);

        push_pair(16'h0100, 16'h0200); push_pair(16'h0080, 16'h0400);
        run_vec("gapped", 3, 1'b0, 0, 16'h0400, 8'd2, 1'b0);

        push_pair(16'hFE00, 16'h0180); push_pair(16'h0300, 16'h0100);
        push_pair(16'h0040, 16'h0400);
        run_vec("stall", 0, 1'b0, 10, 16'h0100, 8'd3, 1'b0);

        push_pair(16'h0100, 16'h0100);
        run_vec("timeout", 0, 1'b1, 0, 16'h0000, 8'd1, 1'b1);

        // Abort a vector mid-accumulation with an asynchronous reset
        s_valid = 1'b1; s_a = 16'h0100; s_b = 16'h0100; s_last = 1'b0;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        chk("abort_busy", busy, 1);
        #2 arst_n = 1'b0;
        #1 chk_reset_state("abort");
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_stale", m_valid, 0);
        end
        push_pair(16'h0100, 16'h0200); push_pair(16'h0080, 16'h0400);
        run_vec("after_abort", 0, 1'b0, 0, 16'h0400, 8'd2, 1'b0);

        for (int i = 0; i < 300; i++) push_pair(16'h0001, 16'h0001);
        run_vec("saturate", 0, 1'b0, 0, 16'h0000, 8'd255, 1'b0);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameters SHALL be: N_LEN, default 16, operand/result width; Q_LEN, default 8, fractional bits (pass-through to the bench model only); DRAIN, default 3, zero-pad cycles after the last pair; MAX_WAIT, default 8, cycles to wait for mac_rvalid; CNT_W, default 8, pair-counter width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 arst_n  in  1  reset, asynchronous and active-low.
REQ-005 s_valid / s_ready  in / out  1 / 1  upstream operand-pair handshake.
REQ-006 s_a, s_b  in  N_LEN each  signed operands; s_last  in  1  marks the final pair of a vector.
REQ-007 mac_ce  out  1  MAC clock enable; mac_sload  out  1  MAC load/dump strobe.
REQ-008 mac_a, mac_b  out  N_LEN each  MAC operands; mac_rvalid  in  1; mac_res  in  N_LEN signed.
REQ-009 m_valid / m_ready  out / in  1 / 1  downstream result handshake.
REQ-010 m_data  out  N_LEN  captured result; m_len  out  CNT_W  pairs in the vector; m_err  out  1  timeout flag.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ACC, DRAIN, WAIT and OUT; all outputs SHALL be registered.
REQ-013 s_ready SHALL be 1 in IDLE and ACC and 0 otherwise; a transfer occurs on an edge where s_valid and s_ready are both 1.
REQ-014 IDLE: mac_sload=1 and mac_a=mac_b=0; a transfer SHALL load mac_a/mac_b from s_a/s_b, clear mac_sload and set the pair count to 1 on the same edge, then go to ACC (or to DRAIN when s_last=1).
REQ-015 ACC: each transfer SHALL load s_a/s_b into mac_a/mac_b on that edge; a cycle with no transfer SHALL load mac_a=mac_b=0, contributing a zero product.
REQ-016 ACC: a transfer with s_last=1 SHALL move to DRAIN; the pair count SHALL saturate at 2^CW-1.
REQ-017 DRAIN: mac_a=mac_b=0 and mac_sload=0 for exactly DRAIN cycles, then go to WAIT with mac_sload=1.
REQ-018 WAIT: mac_sload SHALL be held at 1; mac_rvalid=1 SHALL capture mac_res into m_data, set m_err=0, latch m_len and move to OUT.
REQ-019 WAIT: with no mac_rvalid after MAX_WAIT cycles, the block SHALL set m_data=0, m_err=1, latch m_len and move to OUT.
REQ-020 mac_rvalid in any state other than WAIT SHALL be ignored.
REQ-021 OUT: m_valid=1, with m_data/m_len/m_err held stable until m_ready=1; the handshake edge SHALL clear m_valid and move to IDLE.
REQ-022 Latency: the edge after the last transfer SHALL be the first DRAIN cycle; m_valid SHALL rise on the edge after mac_rvalid is sampled in WAIT.
REQ-023 mac_ce SHALL be 1 in every state, including while stalled in OUT; the accumulator is protected by mac_sload=1.
REQ-024 A new vector SHALL be accepted no earlier than the first cycle back in IDLE (s_ready=0 in OUT).

Reset
REQ-025 arst_n low SHALL immediately force the following, and discard any vector in progress without emitting a result: state=IDLE; s_ready=1; mac_sload=1; mac_ce=1; mac_a=mac_b=0; m_valid=0; m_data=0; m_len=0; m_err=0; busy=0; counters=0.
REQ-026 After reset release, the first edge with s_valid=1 SHALL be accepted normally.

Structure
REQ-027 mac_pkg SHALL hold the FSM state encoding and the default parameter constants (N_LEN, Q_LEN, DRAIN, MAX_WAIT, CNT_W).
REQ-028 The WAIT timeout SHALL be a sub-module, mac_wait_timer: a loadable down-counter with an expiry flag; all other logic SHALL stay in mac_feeder.

Verification
REQ-029 The bench SHALL pair mac_feeder with the team MAC (N_LEN=16, Q_LEN=8).
REQ-030 Two-pair vector (0x0100,0x0200),(0x0080,0x0400) with s_last on the second -> m_data=0x0400, m_len=2, m_err=0.
REQ-031 Single pair (0x0100,0xFF00) with s_last=1 in IDLE -> m_data=0xFF00 (-1.0), m_len=1.
REQ-032 Same two-pair vector with s_valid gapped by 3 idle cycles -> identical result 0x0400; zero pairs do not change the sum.
REQ-033 Hold m_ready=0 for 10 cycles in OUT -> m_valid, m_data and m_len stable, s_ready=0 throughout, and no extra transfer.
REQ-034 Stub mac_rvalid tied to 0 -> after MAX_WAIT=8 WAIT cycles, m_err=1 and m_data=0.
REQ-035 Assert arst_n low mid-ACC, then run a new vector -> no stale m_valid, and the new result matches the bench model.
